// File: rtl/seq_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_ctrl_pkg                                               |
// | Description : Shared constants for the multi-cycle sequencer: opcode     |
// |               values, FSM state encoding, ALU operation encoding and     |
// |               small opcode-classification helpers.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package seq_ctrl_pkg;

  // Opcodes (instr[6:0])
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t c_S_FETCH  = 3'd0;
  localparam state_t c_S_DECODE = 3'd1;
  localparam state_t c_S_EXEC   = 3'd2;
  localparam state_t c_S_MEM    = 3'd3;
  localparam state_t c_S_WB     = 3'd4;
  localparam state_t c_S_TRAP   = 3'd5;

  // ALU operation encoding
  typedef logic [1:0] aluop_t;
  localparam aluop_t c_ALU_ADD   = 2'b00;
  localparam aluop_t c_ALU_SUB   = 2'b01;
  localparam aluop_t c_ALU_FUNCT = 2'b10;

  function automatic logic op_is_legal(input logic [6:0] op);
    return (op == c_OP_IMM) || (op == c_OP_LOAD) || (op == c_OP_STORE) ||
           (op == c_OP_BRANCH) || (op == c_OP_REG);
  endfunction

  function automatic logic op_uses_imm(input logic [6:0] op);
    return (op == c_OP_IMM) || (op == c_OP_LOAD) || (op == c_OP_STORE);
  endfunction

  function automatic aluop_t alu_op_for(input logic [6:0] op);
    if ((op == c_OP_IMM) || (op == c_OP_REG)) return c_ALU_FUNCT;
    if (op == c_OP_BRANCH)                    return c_ALU_SUB;
    return c_ALU_ADD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_ctrl_if                                                |
// | Description : Bundle between the sequencer and its datapath/memories.   |
// |               master : sequencer side (drives requests and enables)      |
// |               slave  : datapath/memory side (drives instr, acks, branch) |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface seq_ctrl_if;
  import seq_ctrl_pkg::*;

  logic [31:0] instr;      // instruction register contents
  logic        imem_ack;   // instruction word returned
  logic        dmem_ack;   // load/store completed
  logic        br_taken;   // branch comparison result
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        pc_we;
  logic        pc_src;     // 0 = PC+4, 1 = PC+imm
  logic        alu_src;    // 0 = register, 1 = immediate
  aluop_t      alu_op;
  logic        reg_we;
  logic        mem_to_reg; // 0 = ALU, 1 = load data
  logic        trap;
  logic [31:0] instret;

  modport master (
    input  instr, imem_ack, dmem_ack, br_taken,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
           alu_src, alu_op, reg_we, mem_to_reg, trap, instret
  );

  modport slave (
    output instr, imem_ack, dmem_ack, br_taken,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
           alu_src, alu_op, reg_we, mem_to_reg, trap, instret
  );
endinterface
`default_nettype wire

// File: rtl/seq_ctrl_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wait_timer                                                 |
// | Description : Memory-wait watchdog. Counts un-acked request cycles and   |
// |               flags the cycle whose miss would reach TIMEOUT.            |
// | Ports       : clk, rst_n  - clock, async active-low reset                |
// |               clear       - zero the count (takes priority)              |
// |               count       - request outstanding and not acked this cycle |
// |               expired     - this un-acked cycle is the TIMEOUT-th one    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clear,
  input  wire logic count,
  output logic      expired
);

  localparam logic [7:0] c_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_cnt <= 8'd0;
    else if (clear)                      r_cnt <= 8'd0;
    else if (count && (r_cnt != c_LAST)) r_cnt <= r_cnt + 8'd1;
  end

  // Gated by count, so an ack in the final allowed cycle never expires.
  assign expired = count && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_ctrl                                                   |
// | Description : Multi-cycle sequencer FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)  |
// |               with memory-wait watchdog and retired-instruction count.  |
// | Ports       : clk    - clock                                             |
// |               rst_n  - async active-low reset                            |
// |               bus    - seq_ctrl_if.master (instr/acks in, controls out)  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  seq_ctrl_if.master  bus
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_run;       // low from reset until the first clock edge after release
  logic [31:0] r_instret;
  logic [6:0]  w_op;
  logic        w_waiting, w_ack, w_expired;
  logic        w_unused_instr;

  logic   w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we, w_pc_src;
  logic   w_alu_src, w_reg_we, w_mem_to_reg, w_trap;
  aluop_t w_alu_op;

  assign w_op           = bus.instr[6:0];
  assign w_unused_instr = ^bus.instr[31:7];

  // Watchdog: only FETCH and MEM wait on an ack; every other state (and
  // the ack cycle itself) clears it, which covers entry to FETCH and MEM.
  assign w_waiting = r_run && ((r_state == c_S_FETCH) || (r_state == c_S_MEM));
  assign w_ack     = (r_state == c_S_FETCH) ? bus.imem_ack : bus.dmem_ack;

  wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!w_waiting || w_ack),
    .count   (w_waiting && !w_ack),
    .expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_run   <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (r_run) begin
      case (r_state)
        c_S_FETCH: begin
          if (bus.imem_ack)   w_state_next = c_S_DECODE;
          else if (w_expired) w_state_next = c_S_TRAP;
        end
        c_S_DECODE: w_state_next = op_is_legal(w_op) ? c_S_EXEC : c_S_TRAP;
        c_S_EXEC: begin
          if (w_op == c_OP_BRANCH)                              w_state_next = c_S_FETCH;
          else if ((w_op == c_OP_LOAD) || (w_op == c_OP_STORE)) w_state_next = c_S_MEM;
          else                                                  w_state_next = c_S_WB;
        end
        c_S_MEM: begin
          if (bus.dmem_ack)   w_state_next = (w_op == c_OP_LOAD) ? c_S_WB : c_S_FETCH;
          else if (w_expired) w_state_next = c_S_TRAP;
        end
        c_S_WB:   w_state_next = c_S_FETCH;
        c_S_TRAP: w_state_next = c_S_TRAP;
        default:  w_state_next = c_S_TRAP;
      endcase
    end
  end

  // Output decode; everything is held at zero until r_run so reset
  // (including an async reset mid-MEM) drops requests immediately.
  always_comb begin
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_src     = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_op     = c_ALU_ADD;
    w_reg_we     = 1'b0;
    w_mem_to_reg = 1'b0;
    w_trap       = 1'b0;
    if (r_run) begin
      case (r_state)
        c_S_FETCH: begin
          w_imem_req = 1'b1;
          w_ir_we    = bus.imem_ack;
        end
        c_S_EXEC: begin
          w_alu_src = op_uses_imm(w_op);
          w_alu_op  = alu_op_for(w_op);
          if (w_op == c_OP_BRANCH) begin
            w_pc_we  = 1'b1;
            w_pc_src = bus.br_taken;
          end
        end
        c_S_MEM: begin
          w_dmem_req = 1'b1;
          w_dmem_we  = (w_op == c_OP_STORE);
          w_pc_we    = (w_op == c_OP_STORE) && bus.dmem_ack;
        end
        c_S_WB: begin
          w_reg_we     = 1'b1;
          w_pc_we      = 1'b1;
          w_mem_to_reg = (w_op == c_OP_LOAD);
        end
        c_S_TRAP: w_trap = 1'b1;
        default: ;
      endcase
    end
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_instret <= 32'd0;
    else if (w_pc_we) r_instret <= r_instret + 32'd1;
  end

  assign bus.imem_req   = w_imem_req;
  assign bus.dmem_req   = w_dmem_req;
  assign bus.dmem_we    = w_dmem_we;
  assign bus.ir_we      = w_ir_we;
  assign bus.pc_we      = w_pc_we;
  assign bus.pc_src     = w_pc_src;
  assign bus.alu_src    = w_alu_src;
  assign bus.alu_op     = w_alu_op;
  assign bus.reg_we     = w_reg_we;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.trap       = w_trap;
  assign bus.instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seq_ctrl                                                |
// | Description : Scoreboard bench for seq_ctrl. Directed instructions push  |
// |               their expected retire record; a negedge monitor pops and   |
// |               compares on every pc_we cycle.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_ctrl_if bus();

  seq_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          lat;     // cycles from first FETCH cycle to retire, inclusive
    int          regwe;   // reg_we cycles seen
    bit          m2r;     // mem_to_reg in retire cycle
    bit          pcsrc;   // pc_src in retire cycle
    logic [1:0]  aop;     // alu_op in EXEC
    bit          asrc;    // alu_src in EXEC
    bit          dwe;     // dmem_we seen
    logic [31:0] iret;    // instret during retire cycle
  } exp_t;

  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad   = 0;
  int n_ret = 0;

  function automatic exp_t mk(input string n, input int lat, input int rwe, input bit m2r,
                              input bit pcs, input logic [1:0] aop, input bit asrc, input bit dwe);
    exp_t x;
    x.name = n; x.lat = lat; x.regwe = rwe; x.m2r = m2r; x.pcsrc = pcs;
    x.aop = aop; x.asrc = asrc; x.dwe = dwe; x.iret = 32'd0;
    return x;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc  = 0;
  int         rwe  = 0;
  int         ecyc = -1;
  bit         dwe  = 1'b0;
  logic [1:0] aop  = 2'b00;
  bit         asrc = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0; rwe = 0; dwe = 1'b0; ecyc = -1;
    end else if (bus.imem_req || cyc > 0) begin
      cyc++;
      if (bus.reg_we)  rwe++;
      if (bus.dmem_we) dwe = 1'b1;
      if (bus.ir_we)   ecyc = cyc + 2;
      if (cyc == ecyc) begin aop = bus.alu_op; asrc = bus.alu_src; end
      if (bus.pc_we) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_retire: pc_we at cycle %0d, required no retire", cyc);
        end else begin
          e = q.pop_front();
          check({e.name, "_latency"},    cyc,            e.lat);
          check({e.name, "_reg_we"},     rwe,            e.regwe);
          check({e.name, "_mem_to_reg"}, bus.mem_to_reg, 32'(e.m2r));
          check({e.name, "_pc_src"},     bus.pc_src,     32'(e.pcsrc));
          check({e.name, "_alu_op"},     aop,            32'(e.aop));
          check({e.name, "_alu_src"},    asrc,           32'(e.asrc));
          check({e.name, "_dmem_we"},    dwe,            32'(e.dwe));
          check({e.name, "_instret"},    bus.instret,    e.iret);
        end
        cyc = 0; rwe = 0; dwe = 1'b0; ecyc = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm, input bit data_side);
    int t = 0;
    while (((data_side ? bus.dmem_req : bus.imem_req) !== 1'b1) && t < 64) begin
      step();
      t++;
    end
    if (t >= 64) begin
      total++; bad++;
      $display("FAIL %s_wait: no request after %0d cycles, required request", nm, t);
    end
  endtask

  task automatic run_instr(input exp_t ex, input logic [31:0] iw, input int fdly,
                           input int ddly, input bit br, input bit mem);
    bus.br_taken = br;
    wait_req(ex.name, 1'b0);
    ex.iret = n_ret;
    n_ret++;
    q.push_back(ex);
    repeat (fdly) step();
    bus.instr    = iw;
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    if (mem) begin
      wait_req(ex.name, 1'b1);
      repeat (ddly) step();
      bus.dmem_ack = 1'b1;
      step();
      bus.dmem_ack = 1'b0;
    end
    wait_req(ex.name, 1'b0);
  endtask

  function automatic logic [11:0] outs();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we, bus.pc_src,
            bus.alu_src, bus.alu_op, bus.reg_we, bus.mem_to_reg, bus.trap};
  endfunction

  // TRAP must hold for n cycles with stray acks ignored and instret frozen.
  task automatic absorb(input string nm, input logic [31:0] iret);
    int viol = 0;
    for (int i = 0; i < 100; i++) begin
      bus.imem_ack = i[0];
      bus.dmem_ack = i[1];
      step();
      if (!(bus.trap === 1'b1 && bus.imem_req === 1'b0 && bus.dmem_req === 1'b0 &&
            bus.pc_we === 1'b0 && bus.reg_we === 1'b0 && bus.ir_we === 1'b0 &&
            bus.instret === iret)) viol++;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    check({nm, "_absorb_violations"}, viol, 0);
  endtask

  task automatic pulse_reset(input string nm);
    rst_n = 1'b0;
    #1;
    check({nm, "_rst_outputs"}, outs(), 12'd0);
    check({nm, "_rst_instret"}, bus.instret, 32'd0);
    step();
    rst_n = 1'b1;
    n_ret = 0;
    wait_req(nm, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.instr    = 32'd0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.br_taken = 1'b0;
    rst_n        = 1'b0;
    repeat (3) step();
    check("reset_outputs", outs(), 12'd0);
    check("reset_instret", bus.instret, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("imem_req_before_first_edge", bus.imem_req, 1'b0);
    step();
    check("imem_req_after_first_edge", bus.imem_req, 1'b1);

    run_instr(mk("addi",     4, 1, 0, 0, 2'b10, 1, 0), 32'h00500093, 0, 0, 0, 0);
    bus.dmem_ack = 1'b1;  // stray data ack outside MEM must be ignored
    run_instr(mk("add",      4, 1, 0, 0, 2'b10, 0, 0), 32'h002081B3, 0, 0, 0, 0);
    bus.dmem_ack = 1'b0;
    run_instr(mk("ld_slow",  8, 1, 1, 0, 2'b00, 1, 0), 32'h0000B103, 0, 3, 0, 1);
    run_instr(mk("ld",       5, 1, 1, 0, 2'b00, 1, 0), 32'h0000B103, 0, 0, 0, 1);
    run_instr(mk("sd",       4, 0, 0, 0, 2'b00, 1, 1), 32'h0020B023, 0, 0, 0, 1);
    run_instr(mk("beq_t",    3, 0, 0, 1, 2'b01, 0, 0), 32'h00208463, 0, 0, 1, 0);
    run_instr(mk("beq_nt",   3, 0, 0, 0, 2'b01, 0, 0), 32'h00208463, 0, 0, 0, 0);
    run_instr(mk("addi_ack16", 19, 1, 0, 0, 2'b10, 1, 0), 32'h00500093, 15, 0, 0, 0);
    check("instret_after_8", bus.instret, 32'd8);

    // Fetch timeout: 16 un-acked FETCH cycles then TRAP.
    repeat (15) step();
    check("fetch16_no_trap", {bus.trap, bus.imem_req}, 2'b01);
    step();
    check("fetch_timeout_trap", {bus.trap, bus.imem_req}, 2'b10);
    absorb("timeout", 32'd8);
    pulse_reset("after_timeout");
    check("after_timeout_trap_clear", bus.trap, 1'b0);

    // Illegal opcode: TRAP right after DECODE.
    bus.instr    = 32'h0000007F;
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("illegal_decode_no_trap", bus.trap, 1'b0);
    step();
    check("illegal_trap", {bus.trap, bus.imem_req}, 2'b10);
    absorb("illegal", 32'd0);
    pulse_reset("after_illegal");

    run_instr(mk("addi_r", 4, 1, 0, 0, 2'b10, 1, 0), 32'h00500093, 0, 0, 0, 0);

    // Store interrupted by reset in its second MEM cycle.
    bus.instr    = 32'h0020B023;
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    wait_req("sd_reset", 1'b1);
    step();
    check("sd_mem2_req", {bus.dmem_req, bus.dmem_we}, 2'b11);
    pulse_reset("sd_reset");
    check("sd_reset_restart_instret", bus.instret, 32'd0);
    run_instr(mk("addi_post", 4, 1, 0, 0, 2'b10, 1, 0), 32'h00500093, 0, 0, 0, 0);

    check("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
